// File: rtl/usb2_ep_sched_pkg.sv
// Shared types and widths for the USB 2.0 endpoint scheduler.
// The package also defines the hs_phase_e encoding used by the four-phase sequencer.
package usb2_pkg;

    localparam int EP_NUM_W = 4;
    localparam int LEN_W    = 10;
    localparam int DATA_W   = 8;

    localparam logic [EP_NUM_W-1:0] EP0 = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMT_HI = 3'd1,
        ST_CMT_LO = 3'd2,
        ST_ARM_HI = 3'd3,
        ST_ARM_LO = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_HI   = 2'd1,
        HS_LO   = 2'd2
    } hs_phase_e;

endpackage

// File: rtl/usb2_ep_sched_if.sv
// Protocol-side interface of the endpoint scheduler. The slave modport is the scheduler.
interface usb2_ep_sched_if
    import usb2_pkg::*;
;
    // Strobes (xfer_start, commit_req, arm_req, buf_in_wren) are single-cycle and
    // are sampled on the rising clock edge. done/err_timeout are one-cycle pulses.
    // buf_in_ready is the ready of the selected endpoint. buf_in_wren is only
    // honoured by that endpoint in a cycle where it is ready.
    logic                xfer_start;
    logic [EP_NUM_W-1:0] xfer_ep;
    logic                buf_in_wren;
    logic                buf_in_ready;
    logic [DATA_W-1:0]   buf_out_q;
    logic [LEN_W-1:0]    buf_out_len;
    logic                buf_out_hasdata;
    logic                commit_req;
    logic                commit_done;
    logic                arm_req;
    logic                arm_done;
    logic                busy;
    logic                ep_invalid;
    logic                err_timeout;
    sched_state_e        state;

    modport master (
        output xfer_start, xfer_ep, buf_in_wren, commit_req, arm_req,
        input  buf_in_ready, buf_out_q, buf_out_len, buf_out_hasdata,
        input  commit_done, arm_done, busy, ep_invalid, err_timeout, state
    );

    modport slave (
        input  xfer_start, xfer_ep, buf_in_wren, commit_req, arm_req,
        output buf_in_ready, buf_out_q, buf_out_len, buf_out_hasdata,
        output commit_done, arm_done, busy, ep_invalid, err_timeout, state
    );

endinterface

// File: rtl/usb2_ep_sched_hs.sv
// Four-phase request/ack sequencer (usb2_ep_hs): raise req, wait ack high, drop req, wait ack low.
// The optional per-phase abort counter is enabled by USB2_EP_SCHED_TIMEOUT_EN.
module usb2_ep_hs
    import usb2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 63
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      ack,
    output logic      req,
    output logic      done,
    output logic      tmo,
    output logic      abort,
    output hs_phase_e phase
);

    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 6) ? $clog2(ACK_TIMEOUT + 1) : 6;

    hs_phase_e phase_q, phase_d;
    logic      req_q, req_d;
    logic      done_q, done_d;
    logic      tmo_q, tmo_d;

`ifdef USB2_EP_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             progress;

    // The counter restarts whenever the phase advances, so the limit applies per phase.
    assign progress = ((phase_q == HS_HI) && ack) || ((phase_q == HS_LO) && !ack);
    assign abort    = (phase_q != HS_IDLE) && !progress &&
                      (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((phase_q == HS_IDLE) || progress || abort) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [CNT_W-1:0] unused_timeout_cfg;

    assign unused_timeout_cfg = CNT_W'(ACK_TIMEOUT);
    assign abort              = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        req_d   = req_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (phase_q)
            HS_IDLE: if (start) begin
                phase_d = HS_HI;
                req_d   = 1'b1;
            end
            HS_HI: if (ack) begin
                phase_d = HS_LO;
                req_d   = 1'b0;
            end
            HS_LO: if (!ack) begin
                phase_d = HS_IDLE;
                done_d  = 1'b1;
            end
            default: phase_d = HS_IDLE;
        endcase
        if (abort) begin
            phase_d = HS_IDLE;
            req_d   = 1'b0;
            done_d  = 1'b0;
            tmo_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= HS_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            req_q   <= req_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign req   = req_q;
    assign done  = done_q;
    assign tmo   = tmo_q;
    assign phase = phase_q;

endmodule

// File: rtl/usb2_ep_sched.sv
// Endpoint scheduler: latches the token's endpoint, muxes the buffer interface to it and
// sequences commit/arm handshakes. USB2_EP_SCHED_TIMEOUT_EN enables handshake timeouts.
module usb2_ep_sched
    import usb2_pkg::*;
#(
    parameter int NUM_EP      = 4,
    parameter int ACK_TIMEOUT = 63
) (
    input  logic                     phy_clk,
    input  logic                     reset,
    usb2_ep_sched_if.slave           bus,
    output logic [NUM_EP-1:0]        ep_wren,
    input  logic [NUM_EP-1:0]        ep_ready,
    output logic [NUM_EP-1:0]        ep_commit,
    input  logic [NUM_EP-1:0]        ep_commit_ack,
    output logic [NUM_EP-1:0]        ep_arm,
    input  logic [NUM_EP-1:0]        ep_arm_ack,
    input  logic [DATA_W*NUM_EP-1:0] ep_q,
    input  logic [LEN_W*NUM_EP-1:0]  ep_len,
    input  logic [NUM_EP-1:0]        ep_hasdata
);

    localparam logic [EP_NUM_W:0] NUM_EP_EXT = (EP_NUM_W + 1)'(NUM_EP);

    logic [EP_NUM_W-1:0] sel_q, sel_d;
    logic                inv_q, inv_d;
    logic                arm_pending_q, arm_pending_d;

    logic [NUM_EP-1:0] sel_oh;
    logic [DATA_W-1:0] mux_q;
    logic [LEN_W-1:0]  mux_len;
    logic              idle, cmt_start, arm_start;
    logic              cmt_ack, cmt_req, cmt_done, cmt_tmo, cmt_abort;
    logic              arm_ack, arm_req_lvl, arm_done, arm_tmo, arm_abort;
    hs_phase_e         cmt_phase, arm_phase;
    sched_state_e      state;

    // An out-of-range sel yields an all-zero one-hot, which blanks the mux and strobes.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (sel_q == EP_NUM_W'(i)) begin
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mux_q   = '0;
        mux_len = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (sel_oh[i]) begin
                mux_q   = ep_q[DATA_W*i +: DATA_W];
                mux_len = ep_len[LEN_W*i +: LEN_W];
            end
        end
    end

    assign idle      = (cmt_phase == HS_IDLE) && (arm_phase == HS_IDLE);
    assign cmt_start = idle && bus.commit_req && !inv_q;
    assign arm_start = idle && !cmt_start && (bus.arm_req || arm_pending_q) && !inv_q;
    assign cmt_ack   = |(ep_commit_ack & sel_oh);
    assign arm_ack   = |(ep_arm_ack & sel_oh);

    always_comb begin
        sel_d         = sel_q;
        inv_d         = inv_q;
        arm_pending_d = arm_pending_q;
        if (idle && bus.xfer_start) begin
            sel_d = bus.xfer_ep;
            inv_d = ({1'b0, bus.xfer_ep} >= NUM_EP_EXT);
        end
        // An arm request that cannot start now is remembered until the FSM is idle.
        if (arm_start) begin
            arm_pending_d = 1'b0;
        end else if (bus.arm_req && !inv_q && (!idle || cmt_start)) begin
            arm_pending_d = 1'b1;
        end
        if (cmt_abort || arm_abort) begin
            arm_pending_d = 1'b0;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            sel_q         <= EP0;
            inv_q         <= 1'b0;
            arm_pending_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            inv_q         <= inv_d;
            arm_pending_q <= arm_pending_d;
        end
    end

    usb2_ep_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_cmt_hs (
        .clk   (phy_clk),
        .rst   (reset),
        .start (cmt_start),
        .ack   (cmt_ack),
        .req   (cmt_req),
        .done  (cmt_done),
        .tmo   (cmt_tmo),
        .abort (cmt_abort),
        .phase (cmt_phase)
    );

    usb2_ep_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_arm_hs (
        .clk   (phy_clk),
        .rst   (reset),
        .start (arm_start),
        .ack   (arm_ack),
        .req   (arm_req_lvl),
        .done  (arm_done),
        .tmo   (arm_tmo),
        .abort (arm_abort),
        .phase (arm_phase)
    );

    always_comb begin
        state = ST_IDLE;
        if (cmt_phase == HS_HI) begin
            state = ST_CMT_HI;
        end else if (cmt_phase == HS_LO) begin
            state = ST_CMT_LO;
        end else if (arm_phase == HS_HI) begin
            state = ST_ARM_HI;
        end else if (arm_phase == HS_LO) begin
            state = ST_ARM_LO;
        end
    end

    assign ep_wren   = sel_oh & {NUM_EP{bus.buf_in_wren}};
    assign ep_commit = sel_oh & {NUM_EP{cmt_req}};
    assign ep_arm    = sel_oh & {NUM_EP{arm_req_lvl}};

    assign bus.buf_in_ready    = |(ep_ready & sel_oh);
    assign bus.buf_out_hasdata = |(ep_hasdata & sel_oh);
    assign bus.buf_out_q       = mux_q;
    assign bus.buf_out_len     = mux_len;
    assign bus.commit_done     = cmt_done;
    assign bus.arm_done        = arm_done;
    assign bus.err_timeout     = cmt_tmo | arm_tmo;
    assign bus.busy            = !idle;
    assign bus.ep_invalid      = inv_q;
    assign bus.state           = state;

endmodule

// File: tb/tb_usb2_ep_sched.sv
// Self-checking bench for usb2_ep_sched: directed stimulus, endpoint ack model and a
// scoreboard of expected done/timeout pulses tagged with the cycle they must appear in.
module tb_usb2_ep_sched;
    import usb2_pkg::*;

    localparam int NUM_EP = 4;
    localparam int SB_W   = 18;
    localparam logic [1:0] K_CMT = 2'd1;
    localparam logic [1:0] K_ARM = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   failed = 0;
    int   t0;
    logic ack_en = 1'b1;

    logic [NUM_EP-1:0]        ep_wren, ep_commit, ep_arm;
    logic [NUM_EP-1:0]        ep_ready      = 4'b0110;
    logic [NUM_EP-1:0]        ep_hasdata    = 4'b0101;
    logic [NUM_EP-1:0]        ep_commit_ack = '0;
    logic [NUM_EP-1:0]        ep_arm_ack    = '0;
    logic [DATA_W*NUM_EP-1:0] ep_q   = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic [LEN_W*NUM_EP-1:0]  ep_len = {10'd40, 10'd18, 10'd7, 10'd3};

    logic [SB_W-1:0] exp_q[$];

    int cmt_wait[NUM_EP], cmt_hold[NUM_EP], arm_wait[NUM_EP], arm_hold[NUM_EP];

    usb2_ep_sched_if bus ();

    usb2_ep_sched #(.NUM_EP(NUM_EP), .ACK_TIMEOUT(63)) dut (
        .phy_clk       (clk),
        .reset         (reset),
        .bus           (bus),
        .ep_wren       (ep_wren),
        .ep_ready      (ep_ready),
        .ep_commit     (ep_commit),
        .ep_commit_ack (ep_commit_ack),
        .ep_arm        (ep_arm),
        .ep_arm_ack    (ep_arm_ack),
        .ep_q          (ep_q),
        .ep_len        (ep_len),
        .ep_hasdata    (ep_hasdata)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Endpoint model: ack 3 cycles after the request rises, hold the ack for 4 cycles.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_EP; i++) begin
            if (reset) begin
                ep_commit_ack[i] <= 1'b0; cmt_wait[i] <= 0; cmt_hold[i] <= 0;
                ep_arm_ack[i]    <= 1'b0; arm_wait[i] <= 0; arm_hold[i] <= 0;
            end else begin
                if (ep_commit_ack[i]) begin
                    if (cmt_hold[i] == 3) begin ep_commit_ack[i] <= 1'b0; cmt_hold[i] <= 0; end
                    else cmt_hold[i] <= cmt_hold[i] + 1;
                end else if (ep_commit[i] && ack_en) begin
                    if (cmt_wait[i] == 2) begin ep_commit_ack[i] <= 1'b1; cmt_wait[i] <= 0; end
                    else cmt_wait[i] <= cmt_wait[i] + 1;
                end else begin
                    cmt_wait[i] <= 0;
                end
                if (ep_arm_ack[i]) begin
                    if (arm_hold[i] == 3) begin ep_arm_ack[i] <= 1'b0; arm_hold[i] <= 0; end
                    else arm_hold[i] <= arm_hold[i] + 1;
                end else if (ep_arm[i] && ack_en) begin
                    if (arm_wait[i] == 2) begin ep_arm_ack[i] <= 1'b1; arm_wait[i] <= 0; end
                    else arm_wait[i] <= arm_wait[i] + 1;
                end else begin
                    arm_wait[i] <= 0;
                end
            end
        end
    end

    // Scoreboard monitor: every pulse must match the head of the expected queue.
    task automatic sb_pop(input logic [1:0] kind);
        logic [SB_W-1:0] act, exp;
        act = {kind, cyc[15:0]};
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected_pulse act(kind,cyc)=%h exp=none", act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                failed++;
                $display("FAIL sb_pulse act(kind,cyc)=%h exp(kind,cyc)=%h", act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.commit_done) sb_pop(K_CMT);
            if (bus.arm_done)    sb_pop(K_ARM);
            if (bus.err_timeout) sb_pop(K_ERR);
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_xfer(input logic [EP_NUM_W-1:0] ep);
        bus.xfer_start = 1'b1;
        bus.xfer_ep    = ep;
        tick(1);
        bus.xfer_start = 1'b0;
    endtask

    task automatic do_req(input logic cmt, input logic arm);
        bus.commit_req = cmt;
        bus.arm_req    = arm;
        tick(1);
        bus.commit_req = 1'b0;
        bus.arm_req    = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        bus.xfer_start  = 1'b0;
        bus.xfer_ep     = '0;
        bus.buf_in_wren = 1'b0;
        bus.commit_req  = 1'b0;
        bus.arm_req     = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state (sel=0 selects EP0)
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_invalid", 32'(bus.ep_invalid), 32'd0);
        chk("rst_commit", 32'(ep_commit), 32'd0);
        chk("rst_arm", 32'(ep_arm), 32'd0);
        chk("rst_pulses", 32'({bus.commit_done, bus.arm_done, bus.err_timeout}), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
        chk("rst_q_ep0", 32'(bus.buf_out_q), 32'h11);

        // Mux to EP2, then EP1
        do_xfer(4'd2);
        chk("ep2_q", 32'(bus.buf_out_q), 32'hA5);
        chk("ep2_len", 32'(bus.buf_out_len), 32'd18);
        chk("ep2_ready", 32'(bus.buf_in_ready), 32'd1);
        chk("ep2_hasdata", 32'(bus.buf_out_hasdata), 32'd1);
        chk("ep2_wren_idle", 32'(ep_wren), 32'd0);
        bus.buf_in_wren = 1'b1;
        #1;
        chk("ep2_wren", 32'(ep_wren), 32'b0100);
        bus.buf_in_wren = 1'b0;
        do_xfer(4'd1);
        chk("ep1_q", 32'(bus.buf_out_q), 32'h22);
        chk("ep1_len", 32'(bus.buf_out_len), 32'd7);
        chk("ep1_hasdata", 32'(bus.buf_out_hasdata), 32'd0);

        // Commit on EP1: ack rises at t0+3, commit drops at t0+4, done at t0+8
        do_req(1'b1, 1'b0);
        exp_q.push_back({K_CMT, 16'(t0 + 8)});
        chk("cmt1_rise", 32'(ep_commit), 32'b0010);
        chk("cmt1_busy", 32'(bus.busy), 32'd1);
        chk("cmt1_state", 32'(bus.state), 32'(ST_CMT_HI));
        tick(3);
        chk("cmt1_ack_hi", 32'(ep_commit_ack), 32'b0010);
        chk("cmt1_held", 32'(ep_commit), 32'b0010);
        tick(1);
        chk("cmt1_fall", 32'(ep_commit), 32'd0);
        chk("cmt1_state_lo", 32'(bus.state), 32'(ST_CMT_LO));
        tick(5);
        chk("cmt1_idle", 32'(bus.busy), 32'd0);

        // Commit and arm together on EP0: arm rises the cycle after commit_done
        do_xfer(4'd0);
        do_req(1'b1, 1'b1);
        exp_q.push_back({K_CMT, 16'(t0 + 8)});
        exp_q.push_back({K_ARM, 16'(t0 + 17)});
        chk("ca_cmt_rise", 32'(ep_commit), 32'b0001);
        chk("ca_arm_wait", 32'(ep_arm), 32'd0);
        tick(8);
        chk("ca_arm_not_yet", 32'(ep_arm), 32'd0);
        tick(1);
        chk("ca_arm_rise", 32'(ep_arm), 32'b0001);
        chk("ca_state", 32'(bus.state), 32'(ST_ARM_HI));
        tick(9);
        chk("ca_idle", 32'(bus.busy), 32'd0);

        // Invalid endpoint
        do_xfer(4'd7);
        bus.buf_in_wren = 1'b1;
        #1;
        chk("inv_flag", 32'(bus.ep_invalid), 32'd1);
        chk("inv_ready", 32'(bus.buf_in_ready), 32'd0);
        chk("inv_wren", 32'(ep_wren), 32'd0);
        chk("inv_q", 32'(bus.buf_out_q), 32'd0);
        chk("inv_len", 32'(bus.buf_out_len), 32'd0);
        chk("inv_hasdata", 32'(bus.buf_out_hasdata), 32'd0);
        bus.buf_in_wren = 1'b0;
        do_req(1'b1, 1'b1);
        chk("inv_no_commit", 32'(ep_commit), 32'd0);
        chk("inv_no_arm", 32'(ep_arm), 32'd0);
        chk("inv_not_busy", 32'(bus.busy), 32'd0);
        tick(10);

        // Endpoint never acks
        ack_en = 1'b0;
        do_xfer(4'd2);
        chk("tmo_valid", 32'(bus.ep_invalid), 32'd0);
        do_req(1'b1, 1'b0);
`ifdef USB2_EP_SCHED_TIMEOUT_EN
        exp_q.push_back({K_ERR, 16'(t0 + 63)});
        tick(62);
        chk("tmo_still_hi", 32'(ep_commit), 32'b0100);
        tick(2);
        chk("tmo_dropped", 32'(ep_commit), 32'd0);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
`else
        tick(70);
        chk("notmo_busy", 32'(bus.busy), 32'd1);
        chk("notmo_commit", 32'(ep_commit), 32'b0100);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("notmo_rst_commit", 32'(ep_commit), 32'd0);
        chk("notmo_rst_busy", 32'(bus.busy), 32'd0);
`endif

        // Reset in the middle of ARM_HI
        do_xfer(4'd3);
        chk("rarm_q", 32'(bus.buf_out_q), 32'h44);
        do_req(1'b0, 1'b1);
        chk("rarm_rise", 32'(ep_arm), 32'b1000);
        chk("rarm_state", 32'(bus.state), 32'(ST_ARM_HI));
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rarm_arm_clr", 32'(ep_arm), 32'd0);
        chk("rarm_busy", 32'(bus.busy), 32'd0);
        chk("rarm_sel0_q", 32'(bus.buf_out_q), 32'h11);
        chk("rarm_sel0_len", 32'(bus.buf_out_len), 32'd3);
        ack_en = 1'b1;
        do_xfer(4'd3);
        chk("rarm_reselect", 32'(bus.buf_out_q), 32'h44);
        do_req(1'b1, 1'b0);
        exp_q.push_back({K_CMT, 16'(t0 + 8)});
        chk("rarm_cmt_rise", 32'(ep_commit), 32'b1000);
        tick(12);
        chk("rarm_cmt_idle", 32'(bus.busy), 32'd0);

        // Drain: every expected pulse must have been consumed
        tick(5);
        while (exp_q.size() > 0) begin
            logic [SB_W-1:0] miss;
            miss = exp_q.pop_front();
            tests++;
            failed++;
            $display("FAIL sb_missing_pulse act=none exp(kind,cyc)=%h", miss);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/usb2_ep_sched.md
Name: usb2_ep_sched

Overview:
Endpoint scheduler between the USB 2.0 protocol layer and up to NUM_EP endpoint buffer blocks (EP0 control plus bulk/interrupt endpoints).
- Latches the endpoint addressed by each token.
- Steers the single protocol-side buffer interface (write strobe, ready, read data, length, hasdata) to that endpoint.
- Sequences the four-phase commit and arm handshakes. Endpoints synchronise these strobes with two flops and ack for about 4 cycles.
- Optionally times out handshakes.

Parameters:
NUM_EP, 4, number of attached endpoints, 1..16; endpoint index 0 is EP0.
ACK_TIMEOUT, 63, cycles allowed per handshake phase before abort; only used with the timeout option.

Ports:
phy_clk  in  1  clock
reset  in  1  synchronous, active-high reset
xfer_start  in  1  pulse: token decoded; latch xfer_ep
xfer_ep  in  4  endpoint number from token
buf_in_wren  in  1  protocol write strobe, forwarded to selected endpoint only
buf_in_ready  out  1  ready of selected endpoint
buf_out_q  out  8  read data of selected endpoint
buf_out_len  out  10  length of selected endpoint
buf_out_hasdata  out  1  hasdata of selected endpoint
commit_req  in  1  pulse: OUT/SETUP data written, commit to selected endpoint
commit_done  out  1  1-cycle pulse: commit handshake completed
arm_req  in  1  pulse: IN data ACKed by host, arm selected endpoint
arm_done  out  1  1-cycle pulse: arm handshake completed
busy  out  1  handshake in progress
ep_invalid  out  1  latched endpoint >= NUM_EP
err_timeout  out  1  1-cycle pulse: handshake aborted
ep_wren  out  NUM_EP  per-endpoint write strobes
ep_ready  in  NUM_EP  per-endpoint buf_in_ready
ep_commit  out  NUM_EP  per-endpoint commit level
ep_commit_ack  in  NUM_EP  per-endpoint commit ack
ep_arm  out  NUM_EP  per-endpoint arm level
ep_arm_ack  in  NUM_EP  per-endpoint arm ack
ep_q  in  8*NUM_EP  packed read data; endpoint i at [8i+7:8i]
ep_len  in  10*NUM_EP  packed lengths
ep_hasdata  in  NUM_EP  per-endpoint hasdata

Behaviour:
- Reset values (reset is synchronous; aborts any handshake in progress):
  - state IDLE, sel=0, ep_invalid=0.
  - ep_commit=0, ep_arm=0, arm_pending=0.
  - commit_done=0, arm_done=0, err_timeout=0, busy=0.
- Selection:
  - xfer_start in IDLE latches sel<=xfer_ep and sets ep_invalid=(xfer_ep>=NUM_EP).
  - xfer_start while busy is ignored.
  - The mux is combinational from registered sel, so data is valid 1 cycle after xfer_start.
  - While ep_invalid: buf_in_ready=0, buf_out_hasdata=0, buf_out_q=0, buf_out_len=0, all ep_wren=0, commit_req/arm_req ignored (no done pulse).
- ep_wren[sel]=buf_in_wren, combinational; all other bits 0.
- FSM states: IDLE, CMT_HI, CMT_LO, ARM_HI, ARM_LO.
- IDLE:
  - commit_req -> CMT_HI, ep_commit[sel]=1.
  - else arm_req or arm_pending -> ARM_HI, ep_arm[sel]=1, arm_pending cleared.
- Simultaneous commit_req and arm_req in IDLE: commit first, arm_pending set.
- arm_req during any non-IDLE state sets arm_pending. commit_req outside IDLE is dropped.
- CMT_HI: on ep_commit_ack[sel]=1, clear ep_commit -> CMT_LO.
- CMT_LO: on ep_commit_ack[sel]=0, commit_done pulse -> IDLE.
- ARM_HI / ARM_LO: same sequence on ep_arm / ep_arm_ack, ending with an arm_done pulse.
- Minimum commit latency is 5 cycles with a 2-flop endpoint synchroniser.
- busy=1 in every state except IDLE.
- sel is frozen while busy.

Optional Feature:
USB2_EP_SCHED_TIMEOUT_EN:
- Defined:
  - A 6+ bit counter, width clog2(ACK_TIMEOUT+1), clears on each state entry and counts in HI/LO states.
  - When it reaches ACK_TIMEOUT: drop ep_commit/ep_arm, pulse err_timeout, no done pulse, clear arm_pending, go to IDLE.
- Undefined: handshakes wait indefinitely; err_timeout is tied 0.

Decomposition:
- Package usb2_pkg holds:
  - Scheduler state encodings.
  - EP_NUM_W=4, LEN_W=10, DATA_W=8.
  - The EP0 index constant.
- One natural sub-module, usb2_ep_hs: a single four-phase request/ack sequencer with the optional timeout, instantiated twice (commit, arm). The mux stays in the top.

Test Plan:
- NUM_EP=4, xfer_start xfer_ep=2, ep_q[23:16]=8'hA5, ep_len[29:20]=10'd18 -> next cycle buf_out_q=8'hA5, buf_out_len=18; buf_in_wren pulses only ep_wren[2].
- commit_req with sel=1; endpoint model acks 3 cycles after ep_commit rises and holds the ack 4 cycles -> ep_commit[1] falls 1 cycle after the ack rises; commit_done pulses once, 1 cycle after the ack falls; busy=0 afterwards.
- commit_req and arm_req in the same cycle, sel=0 -> commit handshake completes first, then ep_arm[0] rises the cycle after commit_done; arm_done pulses once.
- xfer_start xfer_ep=7 with NUM_EP=4 -> ep_invalid=1, buf_in_ready=0, ep_wren=0; a later commit_req produces no ep_commit and no commit_done.
- USB2_EP_SCHED_TIMEOUT_EN, ACK_TIMEOUT=63, endpoint never acks -> err_timeout pulse 63 cycles after entering CMT_HI, ep_commit=0, back to IDLE, no commit_done.
- reset asserted mid-ARM_HI -> next cycle all ep_arm=0, busy=0, sel=0; a subsequent xfer_start is accepted normally.
